// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and buffer entry type for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misalign;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry in-order buffer of fetched instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [CW-1:0] count,
  output logic         head_valid,
  output fetch_entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    r_mem [DEPTH];
  fetch_entry_t    r_last;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            w_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_pop = pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (push && reset && !flush) begin
      r_mem[r_tail] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      // Remember what the consumer last saw so outputs hold once empty.
      if (r_count != '0) begin
        r_last <= r_mem[r_head];
      end
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (push) begin
          r_tail <= next_ptr(r_tail);
        end
        if (w_pop) begin
          r_head <= next_ptr(r_head);
        end
        if (push && !w_pop) begin
          r_count <= r_count + CW'(1);
        end else if (!push && w_pop) begin
          r_count <= r_count - CW'(1);
        end
      end
    end
  end

  assign count      = r_count;
  assign head_valid = (r_count != '0);
  assign head       = (r_count != '0) ? r_mem[r_head] : r_last;

endmodule
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc
// Description : Program counter, redirect handling and fetch-buffer control.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            out_misalign
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   w_count;
  logic            w_fetch_en;
  logic            w_head_valid;
  fetch_entry_t    w_entry;
  fetch_entry_t    w_head;

  // A full buffer may still accept a fetch when its head leaves this cycle.
  assign w_fetch_en = !stall && !redirect_valid &&
                      ((w_count < CW'(DEPTH)) ||
                       ((w_count == CW'(DEPTH)) && out_ready));

  assign w_entry.pc       = r_pc;
  assign w_entry.instr    = imem_rdata;
  assign w_entry.misalign = (r_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_fetch_en) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (w_fetch_en),
    .push_data  (w_entry),
    .pop        (out_ready),
    .count      (w_count),
    .head_valid (w_head_valid),
    .head       (w_head)
  );

  assign imem_addr    = r_pc;
  assign out_valid    = w_head_valid;
  assign out_pc       = w_head.pc;
  assign out_instr    = w_head.instr;
  assign out_misalign = w_head.misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc
// Description : Directed and random stimulus checked against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, out_pc, out_instr;
  logic        out_valid, out_misalign;

  int vectors     = 0;
  int miscompares = 0;

  exp_t        q[$];
  exp_t        last;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ KEY;

  fetch_pc #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misalign   (out_misalign)
  );

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare outputs with the model, apply one cycle of inputs, advance the model.
  task automatic step(input logic rst_n, input logic stl, input logic rv,
                      input logic [31:0] rpc, input logic rdy);
    exp_t e;
    int   n;
    bit   do_fetch;
    check32("imem_addr", imem_addr, m_pc);
    check32("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    e = (q.size() != 0) ? q[0] : last;
    check32("out_pc", out_pc, e.pc);
    check32("out_instr", out_instr, e.instr);
    check32("out_misalign", {31'd0, out_misalign}, {31'd0, e.mis});
    if (q.size() != 0) last = q[0];

    reset = rst_n; stall = stl; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;

    if (!rst_n) begin
      m_pc = RESET_PC;
      q.delete();
      last = '{pc: 32'd0, instr: 32'd0, mis: 1'b0};
    end else if (rv) begin
      q.delete();
      m_pc = rpc;
    end else begin
      n        = q.size();
      do_fetch = !stl && (n < DEPTH || (n == DEPTH && rdy));
      if (n > 0 && rdy) void'(q.pop_front());
      if (do_fetch) begin
        q.push_back('{pc: m_pc, instr: m_pc ^ KEY, mis: m_pc[1:0] != 2'b00});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int cycles, input logic stl, input logic rdy);
    for (int i = 0; i < cycles; i++) step(1'b1, stl, 1'b0, 32'd0, rdy);
  endtask

  initial begin
    logic [31:0] rpc;
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    m_pc = RESET_PC;
    last = '{pc: 32'd0, instr: 32'd0, mis: 1'b0};
    @(posedge clk);
    @(negedge clk);

    // Free run from reset, then back-pressure and release.
    run(5, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    run(5, 1'b0, 1'b0);
    run(4, 1'b0, 1'b1);
    // Redirect while full.
    run(3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
    run(4, 1'b0, 1'b1);
    // Address wrap.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    run(5, 1'b0, 1'b1);
    // Misaligned target, then aligned.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0102, 1'b1);
    run(4, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
    run(4, 1'b0, 1'b1);
    // Reset with two entries buffered and stall asserted.
    run(3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    run(5, 1'b0, 1'b1);
    // Redirect outranks stall.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0);
    run(3, 1'b1, 1'b1);
    run(3, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      rpc = $urandom;
      case ($urandom_range(0, 3))
        0: rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
        1: rpc = rpc & 32'hFFFF_FFFC;
        default: ;
      endcase
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0,
           rpc,
           $urandom_range(0, 9) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter DEPTH, default 2, number of output buffer entries.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-low reset: reset==0 at a posedge clk resets the block.
REQ-005 stall  in  1  1 = suppress new fetches this cycle.
REQ-006 redirect_valid  in  1  1 = branch/jump taken; flush and load redirect_pc.
REQ-007 redirect_pc  in  32  redirect target address.
REQ-008 imem_addr  out  32  instruction memory address; combinational copy of PC register.
REQ-009 imem_rdata  in  32  instruction word for imem_addr, valid the same cycle (asynchronous read).
REQ-010 out_valid  out  1  buffer head holds a valid fetched instruction.
REQ-011 out_ready  in  1  decode accepts the head entry when out_valid && out_ready.
REQ-012 out_pc  out  32  PC of head entry.
REQ-013 out_instr  out  32  instruction word of head entry.
REQ-014 out_misalign  out  1  head entry came from a PC with bits [1:0] != 0.

Function
REQ-015 pc register increments by 32'd4 per fetch; modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000, no flag).
REQ-016 fetch_en = !stall && !redirect_valid && (count < DEPTH || (count == DEPTH && out_ready)).
REQ-017 When fetch_en, same cycle: push {pc, imem_rdata, pc[1:0]!=0} into buffer tail; next pc = pc + 4.
REQ-018 When !fetch_en and !redirect_valid, pc holds and nothing is pushed.
REQ-019 Pop occurs when out_valid && out_ready; head advances next cycle.
REQ-020 Simultaneous push and pop: count unchanged, entries stay in order.
REQ-021 Full (count == DEPTH) without out_ready: no fetch, pc holds, buffer contents hold.
REQ-022 Empty: out_valid = 0; out_pc, out_instr, out_misalign hold last values (don't-care to the consumer).
REQ-023 redirect_valid = 1: buffer flushed (count -> 0), pc <= redirect_pc, no push that cycle; the pop handshake that cycle is ignored; redirect has priority over stall and over fetch.
REQ-024 First instruction from redirect target appears on out_* 2 cycles after redirect_valid is sampled, provided stall = 0.
REQ-025 A misaligned redirect_pc is loaded unchanged; out_misalign = 1 on every entry fetched from it and from its increments.
REQ-026 Latency, empty buffer, no stall: instruction at pc visible on out_* the cycle after fetch.
REQ-027 Throughput: one instruction per cycle sustained with out_ready = 1 and stall = 0.

Reset
REQ-028 On reset: pc = RESET_PC, count = 0, out_valid = 0, out_pc = 0, out_instr = 0, out_misalign = 0.
REQ-029 Reset has priority over redirect_valid, stall and handshakes; reset mid-operation discards buffered entries.
REQ-030 First fetch (of RESET_PC) occurs in the first cycle with reset = 1 and stall = 0.

Structure
REQ-031 Shared package fetch_pkg holds XLEN = 32, PC_STEP = 4, the default RESET_PC, and the buffer entry struct {pc, instr, misalign}.
REQ-032 Buffer is a sub-module fetch_fifo (DEPTH entries, push/pop/flush, count, head outputs); fetch_pc holds pc register and control.

Verification
REQ-033 Reset released, stall = 0, out_ready = 1, imem returns addr ^ 32'hA5A5_0000 -> out_pc 0,4,8,12 on consecutive cycles, matching out_instr.
REQ-034 out_ready = 0 for 5 cycles -> exactly 2 entries (pc 0,4) buffered, imem_addr holds 8, out_pc stays 0; on out_ready = 1, out_pc 0,4,8 with no gap or duplicate.
REQ-035 redirect_valid = 1 with redirect_pc = 32'h0000_0100 while buffer full -> out_valid = 0 next cycle, out_pc = 32'h100 two cycles later, old entries never appear.
REQ-036 pc = 32'hFFFF_FFF8, free-run -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 redirect_pc = 32'h0000_0102 -> out_misalign = 1, out_pc 102, 106; redirect to 32'h200 -> out_misalign = 0.
REQ-038 reset = 0 for one cycle with 2 entries buffered and stall = 1 -> out_valid = 0, imem_addr = RESET_PC; after release, refetch from RESET_PC.
